// File: rtl/ntt_layer_scheduler.sv
// ntt_layer_scheduler
//   Control stage in front of the butterfly unit. Walks all layers of a
//   Kyber-style NTT (Cooley-Tukey order) or INTT (Gentleman-Sande order)
//   over one polynomial in a dual-port coefficient RAM: one butterfly read
//   pair plus zeta index per cycle, then the matching write-back pair once
//   the butterfly pipeline has produced it. Between layers the write-back
//   delay line is drained so a read never overtakes a pending write.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, mode_i         start pulse (ignored while busy), 1=NTT 0=INTT
//   busy_o, done_o          transform in flight / one-cycle completion pulse
//   ct_mode_o               latched mode for the butterfly
//   rd_en_o, rd_addr_a/b_o  RAM read strobe and address pair (j, j+len)
//   zeta_idx_o              zeta ROM address, same cycle as rd_en_o
//   bu_valid_o              butterfly input valid (rd_en_o + RD_LATENCY)
//   wr_en_o, wr_addr_a/b_o  write-back strobe and addresses (rd + D)
//   layer_o                 current layer, debug
module ntt_layer_scheduler #(
  parameter int LOG_N      = 8,
  parameter int NUM_LAYERS = 7,
  parameter int BU_LATENCY = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ct_mode_o,
  output logic             rd_en_o,
  output logic [LOG_N-1:0] rd_addr_a_o,
  output logic [LOG_N-1:0] rd_addr_b_o,
  output logic [LOG_N-2:0] zeta_idx_o,
  output logic             bu_valid_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_a_o,
  output logic [LOG_N-1:0] wr_addr_b_o,
  output logic [2:0]       layer_o
);

  localparam int D  = RD_LATENCY + BU_LATENCY;  // read-to-write-back distance
  localparam int BW = LOG_N - 1;                // butterfly counter width
  localparam logic [2:0] LAST_L = 3'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  typedef struct packed {
    logic [LOG_N-1:0] ra;
    logic [LOG_N-1:0] rb;
    logic [BW-1:0]    z;
  } bfly_t;

  state_t                  state;
  logic [BW-1:0]           b;
  logic [D:1]              vld_pipe;
  logic [D:1][LOG_N-1:0]   wa_pipe;
  logic [D:1][LOG_N-1:0]   wb_pipe;

  // Address pair and zeta index of butterfly bi in layer lay. len is a power
  // of two, so the group/offset split is a shift and a mask, and j+len is an
  // OR because bit log2(len) of j is always clear.
  function automatic bfly_t bfly_addr(input logic ct, input logic [2:0] lay,
                                      input logic [BW-1:0] bi);
    bfly_t            r;
    int               sh;
    logic [LOG_N-1:0] len, g, off, j;
    sh  = ct ? (LOG_N - 1 - int'(lay)) : (int'(lay) + 1);
    len = LOG_N'(1) << sh;
    g   = {1'b0, bi} >> sh;
    off = {1'b0, bi} & (len - LOG_N'(1));
    j   = (g << (sh + 1)) | off;
    r.ra = j;
    r.rb = j | len;
    if (ct) r.z = BW'((LOG_N'(1) << int'(lay)) + g);
    else    r.z = BW'((LOG_N'(1) << (NUM_LAYERS - int'(lay))) - LOG_N'(1) - g);
    return r;
  endfunction

  assign bu_valid_o  = vld_pipe[RD_LATENCY];
  assign wr_en_o     = vld_pipe[D];
  assign wr_addr_a_o = wa_pipe[D];
  assign wr_addr_b_o = wb_pipe[D];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      b           <= '0;
      layer_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ct_mode_o   <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      zeta_idx_o  <= '0;
      vld_pipe    <= '0;
      wa_pipe     <= '0;
      wb_pipe     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[D-1:1], rd_en_o};
      wa_pipe  <= {wa_pipe[D-1:1], rd_addr_a_o};
      wb_pipe  <= {wb_pipe[D-1:1], rd_addr_b_o};
      done_o   <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state     <= ISSUE;
          ct_mode_o <= mode_i;
          layer_o   <= '0;
          b         <= '0;
          busy_o    <= 1'b1;
          rd_en_o   <= 1'b1;
          {rd_addr_a_o, rd_addr_b_o, zeta_idx_o} <= bfly_addr(mode_i, 3'd0, '0);
        end
        ISSUE: if (b == '1) begin
          state   <= DRAIN;
          rd_en_o <= 1'b0;
        end else begin
          b <= b + BW'(1);
          {rd_addr_a_o, rd_addr_b_o, zeta_idx_o} <= bfly_addr(ct_mode_o, layer_o, b + BW'(1));
        end
        // Leave when only the last write of the layer remains in flight; it
        // retires this cycle, so the next layer's first read follows it.
        DRAIN: if (~|vld_pipe[D-1:1]) begin
          if (layer_o == LAST_L) begin
            state  <= FINISH;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state   <= ISSUE;
            layer_o <= layer_o + 3'd1;
            b       <= '0;
            rd_en_o <= 1'b1;
            {rd_addr_a_o, rd_addr_b_o, zeta_idx_o} <= bfly_addr(ct_mode_o, layer_o + 3'd1, '0);
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// Bench for ntt_layer_scheduler: a cycle-offset timeline model of one
// transform (reads at offsets where k mod (N/2+D) < N/2, writes D later,
// done at 7*(N/2+D)), plus a RAM/butterfly model compared against a
// loop-form software NTT, hazard and pulse counters, and literal vectors.
module tb_ntt_layer_scheduler;
  localparam int Q = 3329;
  localparam int LAYER_CYC = 133;
  localparam int TOTAL = 931;

  logic       clk = 1'b0;
  logic       reset_i, start_i, mode_i;
  logic       busy_o, done_o, ct_mode_o, rd_en_o, bu_valid_o, wr_en_o;
  logic [7:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [6:0] zeta_idx_o;
  logic [2:0] layer_o;

  ntt_layer_scheduler dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .ct_mode_o(ct_mode_o), .rd_en_o(rd_en_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .zeta_idx_o(zeta_idx_o),
    .bu_valid_o(bu_valid_o), .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o),
    .wr_addr_b_o(wr_addr_b_o), .layer_o(layer_o)
  );

  always #5 clk = ~clk;

  typedef struct {int ra; int rb;} res_t;
  typedef struct {bit md; int k; bit wr; int a; int b; int z;} lit_t;

  int   checks = 0, failures = 0;
  int   off = -1;
  bit   tmode = 1'b0, just_reset = 1'b0, ram_on = 1'b0;
  int   ram[256], sw[256], pend[256], zetas[128];
  res_t rq[$];
  int   rd_cnt = 0, wr_cnt = 0, hazards = 0, cyc = 0, rd_cyc = 0;
  bit   seen_rd = 1'b0;
  lit_t lits[10];

  function automatic bit is_rd(input int k);
    return (k >= 0) && (k < TOTAL) && ((k % LAYER_CYC) < 128);
  endfunction

  function automatic void exp_addr(input bit m, input int k, output int a,
                                   output int bb, output int z);
    int l, bi, len, g, j;
    l = k / LAYER_CYC; bi = k % LAYER_CYC;
    len = m ? (128 >> l) : (2 << l);
    g = bi / len;
    j = 2 * g * len + bi % len;
    a = j; bb = j + len;
    z = m ? (1 << l) + g : (1 << (7 - l)) - 1 - g;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic sw_ntt();
    int k, zt, t;
    k = 1;
    for (int len = 128; len >= 2; len >>= 1)
      for (int st = 0; st < 256; st += 2 * len) begin
        zt = zetas[k]; k++;
        for (int j = st; j < st + len; j++) begin
          t = zt * sw[j + len] % Q;
          sw[j + len] = (sw[j] - t + Q) % Q;
          sw[j] = (sw[j] + t) % Q;
        end
      end
  endtask

  always @(negedge clk) begin : mon
    logic [47:0] act, ev, msk;
    int a, bb, z, wa, wb, z2, t, lay;
    res_t r;
    cyc++;
    act = {busy_o, done_o, rd_en_o, bu_valid_o, wr_en_o, ct_mode_o, layer_o,
           rd_addr_a_o, rd_addr_b_o, zeta_idx_o, wr_addr_a_o, wr_addr_b_o};
    if (just_reset) begin
      ev = '0; msk = '1;
    end else if (off < 0) begin
      ev = '0; msk = {5'h1f, 43'h0};
    end else begin
      a = 0; bb = 0; z = 0; wa = 0; wb = 0; z2 = 0;
      if (is_rd(off)) exp_addr(tmode, off, a, bb, z);
      if (is_rd(off - 5)) exp_addr(tmode, off - 5, wa, wb, z2);
      lay = off / LAYER_CYC;
      if (lay > 6) lay = 6;
      ev = {off <= TOTAL - 1, off == TOTAL, is_rd(off), is_rd(off - 1), is_rd(off - 5),
            tmode, 3'(lay), 8'(a), 8'(bb), 7'(z), 8'(wa), 8'(wb)};
      msk = {9'h1ff, {23{is_rd(off)}}, {16{is_rd(off - 5)}}};
    end
    checks++;
    if ((act & msk) !== (ev & msk)) begin
      failures++;
      $display("FAIL cycle off=%0d actual=%h expected=%h mask=%h", off, act, ev, msk);
    end

    if (off >= 0 && !just_reset)
      for (int i = 0; i < 10; i++)
        if (lits[i].md == tmode && lits[i].k == off) begin
          if (lits[i].wr)
            check("lit_wr", {wr_en_o, wr_addr_a_o, wr_addr_b_o},
                  {1'b1, 8'(lits[i].a), 8'(lits[i].b)});
          else
            check("lit_rd", {rd_en_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o},
                  {1'b1, 8'(lits[i].a), 8'(lits[i].b), 7'(lits[i].z)});
        end

    // Reads sample the RAM before this cycle's write lands.
    if (rd_en_o === 1'b1) begin
      rd_cnt++;
      if (!seen_rd) begin seen_rd = 1'b1; rd_cyc = cyc; end
      if (pend[rd_addr_a_o] != 0 || pend[rd_addr_b_o] != 0) hazards++;
      pend[rd_addr_a_o]++; pend[rd_addr_b_o]++;
      if (ram_on) begin
        t = zetas[zeta_idx_o] * ram[rd_addr_b_o] % Q;
        r.ra = (ram[rd_addr_a_o] + t) % Q;
        r.rb = (ram[rd_addr_a_o] - t + Q) % Q;
        rq.push_back(r);
      end
    end
    if (wr_en_o === 1'b1) begin
      wr_cnt++;
      if (pend[wr_addr_a_o] > 0) pend[wr_addr_a_o]--;
      if (pend[wr_addr_b_o] > 0) pend[wr_addr_b_o]--;
      if (ram_on && rq.size() > 0) begin
        r = rq.pop_front();
        ram[wr_addr_a_o] = r.ra;
        ram[wr_addr_b_o] = r.rb;
      end
    end
    if (done_o === 1'b1) begin
      check("latency", 64'(cyc - rd_cyc), 64'(TOTAL));
      check("rd_count", 64'(rd_cnt), 64'd896);
      check("wr_count", 64'(wr_cnt), 64'd896);
      check("hazard", 64'(hazards), 64'd0);
      rd_cnt = 0; wr_cnt = 0; hazards = 0; seen_rd = 1'b0;
    end

    just_reset = 1'b0;
    if (reset_i) begin
      off = -1; just_reset = 1'b1;
      rd_cnt = 0; wr_cnt = 0; hazards = 0; seen_rd = 1'b0;
      rq.delete();
      for (int i = 0; i < 256; i++) pend[i] = 0;
    end else if (off < 0) begin
      if (start_i) begin off = 0; tmode = mode_i; end
    end else begin
      off++;
      if (off > TOTAL) off = -1;
    end
  end

  task automatic wait_off(input int target);
    int g;
    g = 0;
    do begin @(posedge clk); g++; end while (off != target && g < 3000);
    check("wait_offset", 64'(off), 64'(target));
  endtask

  task automatic pulse_start(input bit m);
    start_i = 1'b1; mode_i = m;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  initial begin
    int br, p;
    reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    for (int i = 0; i < 128; i++) begin
      br = 0;
      for (int k = 0; k < 7; k++) if (((i >> k) & 1) == 1) br |= 1 << (6 - k);
      p = 1;
      repeat (br) p = p * 17 % Q;
      zetas[i] = p;
    end
    for (int i = 0; i < 256; i++) begin
      ram[i] = int'($urandom_range(0, Q - 1)); sw[i] = ram[i]; pend[i] = 0;
    end
    sw_ntt();
    lits[0] = '{1'b1, 0,   1'b0, 0,   128, 1};
    lits[1] = '{1'b1, 127, 1'b0, 127, 255, 1};
    lits[2] = '{1'b1, 5,   1'b1, 0,   128, 0};
    lits[3] = '{1'b1, 798, 1'b0, 0,   2,   64};
    lits[4] = '{1'b1, 799, 1'b0, 1,   3,   64};
    lits[5] = '{1'b1, 800, 1'b0, 4,   6,   65};
    lits[6] = '{1'b1, 925, 1'b0, 253, 255, 127};
    lits[7] = '{1'b0, 0,   1'b0, 0,   2,   127};
    lits[8] = '{1'b0, 2,   1'b0, 4,   6,   126};
    lits[9] = '{1'b0, 798, 1'b0, 0,   128, 1};

    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(posedge clk); #1;

    // Run 1: NTT with RAM model; a stray INTT start mid-run must be ignored.
    ram_on = 1'b1;
    pulse_start(1'b1);
    repeat (300) @(posedge clk);
    #1 pulse_start(1'b0);
    wait_off(TOTAL);
    #1 ram_on = 1'b0;
    for (int i = 0; i < 256; i++) check("ntt_coef", 64'(ram[i]), 64'(sw[i]));

    // Start held across FINISH (dropped) and the first IDLE cycle (accepted).
    start_i = 1'b1; mode_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_i = 1'b0;
    wait_off(TOTAL);
    repeat (5) @(posedge clk);

    // Run 3: NTT aborted by reset in layer 3.
    #1 pulse_start(1'b1);
    repeat (3 * LAYER_CYC + 50) @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
    repeat (20) @(posedge clk);

    // Run 4: fresh full NTT after the abort.
    #1 pulse_start(1'b1);
    wait_off(TOTAL);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
